fifo_lane_chk: RTL and testbench

Downstream checker for the lane FIFO channel read port. Consumes every word read from the ECC-protected FIFO, checks it against the incrementing-counter pattern written by the channel's pattern generator, and counts ECC single/double-bit events and data mismatches. It also drives the sticky error and warning flags that the channel exports as err_o / pg_warn_o.

---
 rtl/fifo_lane_chk.sv | 126 ++++++++++++
 tb/tb_fifo_lane_chk.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_lane_chk.sv
// Read-side pattern checker for the lane FIFO: seeds on the first clean word,
// then tracks the incrementing counter and tallies ECC events and mismatches.
module fifo_lane_chk #(
  parameter int N        = 32,
  parameter int CNT_W    = 16,
  parameter int WARN_THR = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [N-1:0]     data_i,
  input  logic             valid_i,
  input  logic             sbiterr_i,
  input  logic             dbiterr_i,
  output logic             locked_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [CNT_W-1:0] mism_cnt_o,
  output logic [CNT_W-1:0] sbit_cnt_o,
  output logic [CNT_W-1:0] dbit_cnt_o,
  output logic             err_o,
  output logic             warn_o
);

  typedef enum logic {IDLE, CHECK} state_t;

  localparam logic [CNT_W-1:0] WARN_LVL = CNT_W'(WARN_THR);

  state_t           state_p0, state_nxt;
  logic [N-1:0]     exp_p0, exp_nxt;
  logic             locked_p0, locked_nxt;
  logic             err_p0, err_nxt;
  logic [CNT_W-1:0] word_p0, word_nxt;
  logic [CNT_W-1:0] mism_p0, mism_nxt;
  logic [CNT_W-1:0] sbit_p0, sbit_nxt;
  logic [CNT_W-1:0] dbit_p0, dbit_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_nxt  = state_p0;
    exp_nxt    = exp_p0;
    locked_nxt = locked_p0;
    err_nxt    = err_p0;
    word_nxt   = word_p0;
    mism_nxt   = mism_p0;
    sbit_nxt   = sbit_p0;
    dbit_nxt   = dbit_p0;

    if (valid_i) begin
      if (sbiterr_i) sbit_nxt = sat_inc(sbit_p0);
      if (dbiterr_i) begin
        dbit_nxt = sat_inc(dbit_p0);
        err_nxt  = 1'b1;
      end

      unique case (state_p0)
        IDLE: begin
          // Never seed from a word the ECC could not repair.
          if (!dbiterr_i) begin
            exp_nxt    = data_i + 1'b1;
            word_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
            locked_nxt = 1'b1;
            state_nxt  = CHECK;
          end
        end
        CHECK: begin
          word_nxt = sat_inc(word_p0);
          if (dbiterr_i) begin
            exp_nxt = exp_p0 + 1'b1;
          end else if (data_i != exp_p0) begin
            // Resync on the observed word so one drop costs one mismatch.
            mism_nxt = sat_inc(mism_p0);
            err_nxt  = 1'b1;
            exp_nxt  = data_i + 1'b1;
          end else begin
            exp_nxt = exp_p0 + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0: result registers; clear has priority over any incoming word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p0  <= IDLE;
      exp_p0    <= '0;
      locked_p0 <= 1'b0;
      err_p0    <= 1'b0;
      word_p0   <= '0;
      mism_p0   <= '0;
      sbit_p0   <= '0;
      dbit_p0   <= '0;
    end else if (clr_i) begin
      state_p0  <= IDLE;
      exp_p0    <= '0;
      locked_p0 <= 1'b0;
      err_p0    <= 1'b0;
      word_p0   <= '0;
      mism_p0   <= '0;
      sbit_p0   <= '0;
      dbit_p0   <= '0;
    end else begin
      state_p0  <= state_nxt;
      exp_p0    <= exp_nxt;
      locked_p0 <= locked_nxt;
      err_p0    <= err_nxt;
      word_p0   <= word_nxt;
      mism_p0   <= mism_nxt;
      sbit_p0   <= sbit_nxt;
      dbit_p0   <= dbit_nxt;
    end
  end

  assign locked_o   = locked_p0;
  assign err_o      = err_p0;
  assign word_cnt_o = word_p0;
  assign mism_cnt_o = mism_p0;
  assign sbit_cnt_o = sbit_p0;
  assign dbit_cnt_o = dbit_p0;
  assign warn_o     = (mism_p0 >= WARN_LVL);

endmodule

// File: tb/tb_fifo_lane_chk.sv
// Directed bench for fifo_lane_chk: a 16-bit-counter and a 4-bit-counter
// instance share one stimulus and are compared against an unbounded-count model.
module tb_fifo_lane_chk;

  localparam int N = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clr_i = 1'b0;
  logic [N-1:0]  data_i = '0;
  logic          valid_i = 1'b0;
  logic          sbiterr_i = 1'b0;
  logic          dbiterr_i = 1'b0;

  logic          a_locked, a_err, a_warn;
  logic [15:0]   a_word, a_mism, a_sbit, a_dbit;
  logic          b_locked, b_err, b_warn;
  logic [3:0]    b_word, b_mism, b_sbit, b_dbit;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  fifo_lane_chk #(.N(N), .CNT_W(16), .WARN_THR(1)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .data_i(data_i),
    .valid_i(valid_i), .sbiterr_i(sbiterr_i), .dbiterr_i(dbiterr_i),
    .locked_o(a_locked), .word_cnt_o(a_word), .mism_cnt_o(a_mism),
    .sbit_cnt_o(a_sbit), .dbit_cnt_o(a_dbit), .err_o(a_err), .warn_o(a_warn));

  fifo_lane_chk #(.N(N), .CNT_W(4), .WARN_THR(1)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .data_i(data_i),
    .valid_i(valid_i), .sbiterr_i(sbiterr_i), .dbiterr_i(dbiterr_i),
    .locked_o(b_locked), .word_cnt_o(b_word), .mism_cnt_o(b_mism),
    .sbit_cnt_o(b_sbit), .dbit_cnt_o(b_dbit), .err_o(b_err), .warn_o(b_warn));

  // Behavioural model: counts are unbounded integers, saturation applied on compare.
  int         m_word = 0, m_mism = 0, m_sbit = 0, m_dbit = 0;
  bit         m_locked = 0, m_err = 0;
  logic [N-1:0] m_exp = '0;

  task automatic model_clear();
    m_word = 0; m_mism = 0; m_sbit = 0; m_dbit = 0;
    m_locked = 0; m_err = 0; m_exp = '0;
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clr_i) begin
      model_clear();
    end else if (valid_i) begin
      if (sbiterr_i) m_sbit = m_sbit + 1;
      if (dbiterr_i) begin
        m_dbit = m_dbit + 1;
        m_err  = 1;
      end
      if (!m_locked) begin
        if (!dbiterr_i) begin
          m_locked = 1;
          m_word   = 1;
          m_exp    = data_i + 1;
        end
      end else begin
        m_word = m_word + 1;
        if (dbiterr_i) begin
          m_exp = m_exp + 1;
        end else begin
          if (data_i != m_exp) begin
            m_mism = m_mism + 1;
            m_err  = 1;
          end
          m_exp = data_i + 1;
        end
      end
    end
  end

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    chk("a.locked", 32'(a_locked), 32'(m_locked));
    chk("a.word",   32'(a_word),   32'(sat(m_word, 16)));
    chk("a.mism",   32'(a_mism),   32'(sat(m_mism, 16)));
    chk("a.sbit",   32'(a_sbit),   32'(sat(m_sbit, 16)));
    chk("a.dbit",   32'(a_dbit),   32'(sat(m_dbit, 16)));
    chk("a.err",    32'(a_err),    32'(m_err));
    chk("a.warn",   32'(a_warn),   32'(m_mism >= 1));
    chk("b.locked", 32'(b_locked), 32'(m_locked));
    chk("b.word",   32'(b_word),   32'(sat(m_word, 4)));
    chk("b.mism",   32'(b_mism),   32'(sat(m_mism, 4)));
    chk("b.sbit",   32'(b_sbit),   32'(sat(m_sbit, 4)));
    chk("b.dbit",   32'(b_dbit),   32'(sat(m_dbit, 4)));
    chk("b.err",    32'(b_err),    32'(m_err));
    chk("b.warn",   32'(b_warn),   32'(m_mism >= 1));
  end

  // Drive one cycle of inputs; returns 1ns after the sampling edge.
  task automatic cyc(input logic [N-1:0] d, input bit v, input bit sb, input bit db, input bit c);
    data_i = d; valid_i = v; sbiterr_i = sb; dbiterr_i = db; clr_i = c;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0; sbiterr_i = 1'b0; dbiterr_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic word(input logic [N-1:0] d);
    cyc(d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst.locked", 32'(a_locked), 32'd0);
    chk("rst.word",   32'(a_word),   32'd0);
    chk("rst.err",    32'(a_err),    32'd0);
    chk("rst.warn",   32'(a_warn),   32'd0);

    // 100 clean words 0x05..0x68
    word(32'h5);
    chk("seed.locked", 32'(a_locked), 32'd1);
    chk("seed.word",   32'(a_word),   32'd1);
    for (int i = 6; i <= 32'h68; i++) word(32'(i));
    chk("run.word", 32'(a_word), 32'd100);
    chk("run.mism", 32'(a_mism), 32'd0);
    chk("run.err",  32'(a_err),  32'd0);
    chk("run.warn", 32'(a_warn), 32'd0);
    chk("run.bword_sat", 32'(b_word), 32'd15);

    // Flags with valid_i=0 are ignored
    cyc(32'h1234, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("idle_ecc.dbit", 32'(a_dbit), 32'd0);

    // Skipped word 0x11
    clear();
    word(32'h0E); word(32'h0F); word(32'h10);
    word(32'h12); word(32'h13); word(32'h14); word(32'h15); word(32'h16);
    chk("skip.mism", 32'(a_mism), 32'd1);
    chk("skip.err",  32'(a_err),  32'd1);
    chk("skip.warn", 32'(a_warn), 32'd1);
    chk("skip.word", 32'(a_word), 32'd8);

    // Double-bit error on 0x20 with garbage data
    clear();
    word(32'h1E); word(32'h1F);
    cyc(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0);
    word(32'h21); word(32'h22);
    chk("dbit.dbit", 32'(a_dbit), 32'd1);
    chk("dbit.mism", 32'(a_mism), 32'd0);
    chk("dbit.err",  32'(a_err),  32'd1);
    cyc(32'h0BAD_0BAD, 1'b1, 1'b1, 1'b1, 1'b0);
    word(32'h24);
    chk("both.dbit", 32'(a_dbit), 32'd2);
    chk("both.sbit", 32'(a_sbit), 32'd1);
    chk("both.mism", 32'(a_mism), 32'd0);

    // Double-bit error on the first word after reset
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    cyc(32'h40, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("dseed.locked", 32'(a_locked), 32'd0);
    chk("dseed.dbit",   32'(a_dbit),   32'd1);
    word(32'h41);
    chk("dseed.relock", 32'(a_locked), 32'd1);
    chk("dseed.word",   32'(a_word),   32'd1);
    word(32'h42);
    chk("dseed.mism",   32'(a_mism),   32'd0);

    // Single-bit corrections on three correct words
    clear();
    word(32'h30);
    cyc(32'h31, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(32'h32, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(32'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    word(32'h34);
    chk("sbit.sbit", 32'(a_sbit), 32'd3);
    chk("sbit.mism", 32'(a_mism), 32'd0);
    chk("sbit.err",  32'(a_err),  32'd0);

    // Expected-value wrap
    clear();
    word(32'hFFFF_FFFE); word(32'hFFFF_FFFF); word(32'h0); word(32'h1);
    chk("wrap.mism", 32'(a_mism), 32'd0);
    chk("wrap.err",  32'(a_err),  32'd0);

    // 20 mismatches: 4-bit counter holds at 15
    clear();
    word(32'h0);
    for (int i = 1; i <= 20; i++) word(32'(2 * i));
    chk("sat.amism", 32'(a_mism), 32'd20);
    chk("sat.bmism", 32'(b_mism), 32'd15);
    chk("sat.bwarn", 32'(b_warn), 32'd1);

    // Clear together with a valid word
    clear();
    word(32'h4E); word(32'h4F);
    cyc(32'h50, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr.locked", 32'(a_locked), 32'd0);
    chk("clr.word",   32'(a_word),   32'd0);
    chk("clr.dbit",   32'(a_dbit),   32'd0);
    chk("clr.err",    32'(a_err),    32'd0);
    word(32'h51);
    chk("clr.seed",   32'(a_word),   32'd1);
    chk("clr.locked1", 32'(a_locked), 32'd1);
    word(32'h52);

    // Asynchronous reset mid-stream
    word(32'h53); word(32'h54);
    data_i = 32'h55; valid_i = 1'b1;
    #3 rst_i = 1'b1;
    #1;
    chk("arst.locked", 32'(a_locked), 32'd0);
    chk("arst.word",   32'(a_word),   32'd0);
    chk("arst.blocked", 32'(b_locked), 32'd0);
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    word(32'h70); word(32'h71); word(32'h72);
    chk("arst.relock", 32'(a_locked), 32'd1);
    chk("arst.word3",  32'(a_word),   32'd3);
    chk("arst.mism",   32'(a_mism),   32'd0);

    repeat (2) @(posedge clk_i);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
